enemy_laser_pool: RTL and testbench
===================================

# enemy_laser_pool

Parametrised enemy weapon block: one enemy owns a pool of `NUM_LASERS` independent downward-moving lasers. A pseudo-random trigger fires them, subject to a per-enemy cooldown, and an optional aimed mode drifts each laser horizontally toward the player. The block sits between the enemy movement logic (which supplies the enemy position), the LFSR, the player-ship module and the colour mapper. It reports per-slot laser positions and a single-frame player-hit pulse.

## Interface
- `NUM_LASERS`, 4: laser slots per enemy, range 1–8.
- `SPEED`, 6: vertical pixels per frame.
- `COOLDOWN`, 16: minimum frames between spawns, range 0–255.
- `AIMED`, 0: 1 enables horizontal drift toward the player.
- `DRIFT`, 1: horizontal pixels per frame when `AIMED`=1.
- `SPAWN_DY`, 16: laser Y offset below the enemy origin.
- `SPAWN_DX`, 2: laser X offset from the enemy origin.
- `Y_MAX`, 479: last visible row.
- `MARGIN`, 7: bottom retirement margin.
- `X_MAX`, 639: last visible column.
- `frame_clk` in 1: frame-rate clock; all state changes on its rising edge.
- `Reset_n` in 1: asynchronous, active-low reset.
- `LFSR` in 6: random value; a value of 0 requests a shot.
- `EX`, `EY` in 10 each: enemy origin.
- `enemy_alive` in 1: enemy may fire.
- `PSX`, `PSY` in 10 each: player ship origin.
- `laser_width`, `laser_height` in 10 each: laser sprite size.
- `laserX`, `laserY` out 10×`NUM_LASERS` each, packed: slot i occupies bits [10i+9:10i].
- `laser_valid` out `NUM_LASERS`: slot active.
- `Phit` out 1: player was hit this frame.
- `active_count` out 4: number of set `laser_valid` bits.

## Operation
- Shot request `shoot_q` is a register loaded with (`LFSR`==0) every frame. This gives one frame of latency from `LFSR` to fire.
- Fire condition, evaluated every frame: `shoot_q` && `enemy_alive` && `cooldown`==0 && at least one slot invalid at the start of the frame.
- Spawn:
  - The lowest-index invalid slot becomes valid.
  - Its X is loaded with `EX`+`SPAWN_DX` and its Y with `EY`+`SPAWN_DY`.
  - `cooldown` is loaded with `COOLDOWN`.
  - Only one spawn per frame.
- Cooldown: when nonzero, `cooldown` decrements by 1 per frame. A spawn takes priority over the decrement.
- Per valid slot, in priority order each frame:
  1. Retire: if `laserY`+`laser_height` >= `Y_MAX`−`MARGIN`, the slot goes invalid and X/Y go to 0.
  2. Hit: if the laser overlaps the player using inclusive AABB at the current (pre-move) position, the slot goes invalid, X/Y go to 0, and the frame is a hit. Overlap means `laserX` <= `PSX`+30 && `laserX`+`laser_width` >= `PSX` && `laserY` <= `PSY`+30 && `laserY`+`laser_height` >= `PSY`.
  3. Move: `laserY` += `SPEED`. If `AIMED`, `laserX` moves by `DRIFT` toward `PSX`. It stays put when |`laserX`−`PSX`| < `DRIFT`, and is clamped to the range 0..`X_MAX`−`laser_width`.
- `Phit` is registered and is 1 for exactly one frame when one or more slots hit in a frame; otherwise it is 0. Simultaneous hits in one frame produce a single pulse.
- A slot retired or hit in frame N is not reusable until frame N+1.
- Lasers already in flight continue moving when `enemy_alive` drops; only new spawns are blocked.
- All arithmetic is 11-bit internally so sums do not wrap. A spawn position that already satisfies the retire rule is retired on the next frame without ever being hit-checked.

## Timing
- Reset (`Reset_n`=0, asynchronous) drives:
  - all `laser_valid`=0, all `laserX`/`laserY`=0;
  - `Phit`=0, `active_count`=0;
  - `cooldown`=0, `shoot_q`=0.
- A reset applied mid-flight clears every slot immediately, without waiting for a clock edge.
- `LFSR`=0 in frame N causes `laser_valid` to rise after the frame N+1 edge, given the other fire conditions hold.
- `Phit` and the hit slot's `laser_valid` drop are visible after the same edge.
- `active_count` is registered and reflects the slot state after the edge.
- Minimum spawn spacing is `COOLDOWN`+1 frames.

## Structure
- Shared package `game_pkg` holds:
  - `SCREEN_X_MAX`, `SCREEN_Y_MAX`;
  - `PLAYERSHIP_W`/`PLAYERSHIP_H`=30;
  - `pos_t` (10-bit position type).
- Sub-module `enemy_laser_slot`: one laser's X/Y/valid registers with its own retire, hit and move logic. It takes a spawn strobe plus spawn coordinates and outputs X, Y, valid and hit.
- The top level contains the `shoot_q` register, cooldown counter, free-slot priority encoder, hit OR-reduction and popcount.

## Test plan
- Reset then `LFSR`=0 for one frame with `EX`=100, `EY`=50 → after 2 edges: slot0 valid at (102, 66); 1 frame later slot0 is at Y=72.
- `LFSR` held at 0, `COOLDOWN`=16 → spawns 17 frames apart; slots 0,1,2,3 fill in order; `active_count` caps at 4; the fifth request is ignored until a slot frees.
- Laser falling with `laser_height`=8 → it retires on the frame where Y+8 >= 472; that slot respawns no earlier than the next frame.
- `PSX`=100, `PSY`=400 under a laser at X=102 → `Phit` is 1 for one frame, the slot goes invalid, X/Y are 0; two lasers hitting together still produce one pulse.
- `AIMED`=1, `DRIFT`=1, laser at X=102, `PSX`=200 → X increments by 1 per frame; at `PSX`=0 it clamps at 0.
- `Reset_n` pulsed low mid-frame with 3 lasers active → all outputs are 0 immediately; `enemy_alive`=0 with `LFSR`=0 → no spawn, and existing lasers keep falling.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game constants and types.
// Holds the screen extents, the player ship sprite size, and the position
// types used by the game blocks. A position is 10 bits; wide_t is the
// 11-bit type used for sums, so a position plus an offset cannot wrap.
package game_pkg;

  localparam int SCREEN_X_MAX = 639;
  localparam int SCREEN_Y_MAX = 479;
  localparam int PLAYERSHIP_W = 30;
  localparam int PLAYERSHIP_H = 30;

  typedef logic [9:0]  pos_t;
  typedef logic [10:0] wide_t;

endpackage

// File: rtl/enemy_laser_slot.sv
// One enemy laser: X/Y/valid registers plus this laser's retire, hit and
// move logic for one frame.
// Ports:
//   frame_clk, Reset_n       frame clock, async active-low reset
//   spawn                    load spawn_x/spawn_y and become valid
//   spawn_x, spawn_y         spawn position
//   psx, psy                 player ship origin
//   laser_width/height       laser sprite size
//   laser_x, laser_y, valid  registered laser state
//   valid_next               valid as it will be after this edge
//   hit                      laser overlaps the player this frame
module enemy_laser_slot
  import game_pkg::*;
#(
  parameter int SPEED  = 6,
  parameter int AIMED  = 0,
  parameter int DRIFT  = 1,
  parameter int Y_MAX  = SCREEN_Y_MAX,
  parameter int MARGIN = 7,
  parameter int X_MAX  = SCREEN_X_MAX
) (
  input  logic frame_clk,
  input  logic Reset_n,
  input  logic spawn,
  input  pos_t spawn_x,
  input  pos_t spawn_y,
  input  pos_t psx,
  input  pos_t psy,
  input  pos_t laser_width,
  input  pos_t laser_height,
  output pos_t laser_x,
  output pos_t laser_y,
  output logic valid,
  output logic valid_next,
  output logic hit
);

  localparam wide_t RETIRE_ROW = wide_t'(Y_MAX - MARGIN);
  localparam wide_t SHIP_W     = wide_t'(PLAYERSHIP_W);
  localparam wide_t SHIP_H     = wide_t'(PLAYERSHIP_H);
  localparam wide_t SPEED_W    = wide_t'(SPEED);
  localparam wide_t DRIFT_W    = wide_t'(DRIFT);
  localparam wide_t X_MAX_W    = wide_t'(X_MAX);

  pos_t x_q, x_d, y_q, y_d;
  logic valid_q, valid_d;

  wide_t x_w, y_w, psx_w, psy_w, w_w, h_w;
  wide_t x_hi, x_step, x_moved;
  logic  retire, overlap;

  assign x_w   = {1'b0, x_q};
  assign y_w   = {1'b0, y_q};
  assign psx_w = {1'b0, psx};
  assign psy_w = {1'b0, psy};
  assign w_w   = {1'b0, laser_width};
  assign h_w   = {1'b0, laser_height};

  // Retire outranks hit, so a laser spawned inside the retire band is never
  // hit-checked.
  assign retire  = valid_q && (y_w + h_w >= RETIRE_ROW);
  assign overlap = (x_w <= psx_w + SHIP_W) && (x_w + w_w >= psx_w) &&
                   (y_w <= psy_w + SHIP_H) && (y_w + h_w >= psy_w);
  assign hit     = valid_q && !retire && overlap;

  // Drift toward the player only when at least DRIFT pixels away; the
  // subtraction branch cannot go negative, so only the right edge needs a
  // clamp.
  always_comb begin
    x_hi = (w_w > X_MAX_W) ? '0 : X_MAX_W - w_w;
    if (x_w >= psx_w + DRIFT_W)      x_step = x_w - DRIFT_W;
    else if (psx_w >= x_w + DRIFT_W) x_step = x_w + DRIFT_W;
    else                             x_step = x_w;
    x_moved = (x_step > x_hi) ? x_hi : x_step;
  end

  // NOTE: every always_comb output gets its default first so no path can
  // leave a value held, which would infer a latch.
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    valid_d = valid_q;
    if (spawn) begin
      valid_d = 1'b1;
      x_d     = spawn_x;
      y_d     = spawn_y;
    end else if (valid_q) begin
      if (retire || hit) begin
        valid_d = 1'b0;
        x_d     = '0;
        y_d     = '0;
      end else begin
        y_d = pos_t'(y_w + SPEED_W);
        if (AIMED != 0) x_d = pos_t'(x_moved);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      x_q     <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      valid_q <= valid_d;
    end
  end

  assign laser_x    = x_q;
  assign laser_y    = y_q;
  assign valid      = valid_q;
  assign valid_next = valid_d;

endmodule

// File: rtl/enemy_laser_pool.sv
// Enemy weapon: a pool of NUM_LASERS falling lasers fired by a registered
// LFSR shot request, throttled by a cooldown counter.
// Ports:
//   frame_clk, Reset_n        frame clock, async active-low reset
//   LFSR                      random value, 0 requests a shot
//   EX, EY, enemy_alive       enemy origin and fire enable
//   PSX, PSY                  player ship origin
//   laser_width/height        laser sprite size
//   laserX, laserY            packed per-slot positions, slot i at [10i+9:10i]
//   laser_valid               per-slot active flags
//   Phit                      one-frame pulse when any laser hit the player
//   active_count              number of active slots
module enemy_laser_pool
  import game_pkg::*;
#(
  parameter int NUM_LASERS = 4,
  parameter int SPEED      = 6,
  parameter int COOLDOWN   = 16,
  parameter int AIMED      = 0,
  parameter int DRIFT      = 1,
  parameter int SPAWN_DY   = 16,
  parameter int SPAWN_DX   = 2,
  parameter int Y_MAX      = SCREEN_Y_MAX,
  parameter int MARGIN     = 7,
  parameter int X_MAX      = SCREEN_X_MAX
) (
  input  logic                    frame_clk,
  input  logic                    Reset_n,
  input  logic [5:0]              LFSR,
  input  logic [9:0]              EX,
  input  logic [9:0]              EY,
  input  logic                    enemy_alive,
  input  logic [9:0]              PSX,
  input  logic [9:0]              PSY,
  input  logic [9:0]              laser_width,
  input  logic [9:0]              laser_height,
  output logic [10*NUM_LASERS-1:0] laserX,
  output logic [10*NUM_LASERS-1:0] laserY,
  output logic [NUM_LASERS-1:0]   laser_valid,
  output logic                    Phit,
  output logic [3:0]              active_count
);

  localparam logic [7:0] COOLDOWN_INIT = 8'(COOLDOWN);

  logic                  shoot_q, shoot_d;
  logic [7:0]            cooldown_q, cooldown_d;
  logic                  phit_q, phit_d;
  logic [3:0]            active_count_q, active_count_d;
  logic [NUM_LASERS-1:0] spawn_vec, slot_hit, valid_next;
  logic                  fire, found;
  pos_t                  spawn_x, spawn_y;

  assign spawn_x = pos_t'({1'b0, EX} + wide_t'(SPAWN_DX));
  assign spawn_y = pos_t'({1'b0, EY} + wide_t'(SPAWN_DY));

  for (genvar i = 0; i < NUM_LASERS; i++) begin : g_slot
    enemy_laser_slot #(
      .SPEED (SPEED),
      .AIMED (AIMED),
      .DRIFT (DRIFT),
      .Y_MAX (Y_MAX),
      .MARGIN(MARGIN),
      .X_MAX (X_MAX)
    ) u_slot (
      .frame_clk   (frame_clk),
      .Reset_n     (Reset_n),
      .spawn       (spawn_vec[i]),
      .spawn_x     (spawn_x),
      .spawn_y     (spawn_y),
      .psx         (PSX),
      .psy         (PSY),
      .laser_width (laser_width),
      .laser_height(laser_height),
      .laser_x     (laserX[10*i +: 10]),
      .laser_y     (laserY[10*i +: 10]),
      .valid       (laser_valid[i]),
      .valid_next  (valid_next[i]),
      .hit         (slot_hit[i])
    );
  end

  // Free slots are judged on the registered valid bits, so a slot retired
  // or hit this frame only becomes available next frame.
  always_comb begin
    shoot_d   = (LFSR == 6'd0);
    fire      = shoot_q && enemy_alive && (cooldown_q == 8'd0) && !(&laser_valid);
    spawn_vec = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_LASERS; i++) begin
      if (fire && !laser_valid[i] && !found) begin
        spawn_vec[i] = 1'b1;
        found        = 1'b1;
      end
    end

    if (fire)                     cooldown_d = COOLDOWN_INIT;
    else if (cooldown_q != 8'd0)  cooldown_d = cooldown_q - 8'd1;
    else                          cooldown_d = cooldown_q;

    phit_d         = |slot_hit;
    active_count_d = '0;
    for (int i = 0; i < NUM_LASERS; i++) begin
      active_count_d = active_count_d + 4'(valid_next[i]);
    end
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      shoot_q        <= 1'b0;
      cooldown_q     <= '0;
      phit_q         <= 1'b0;
      active_count_q <= '0;
    end else begin
      shoot_q        <= shoot_d;
      cooldown_q     <= cooldown_d;
      phit_q         <= phit_d;
      active_count_q <= active_count_d;
    end
  end

  assign Phit         = phit_q;
  assign active_count = active_count_q;

endmodule

// File: tb/tb_enemy_laser_pool.sv
// Self-checking bench for enemy_laser_pool. Two instances share stimulus:
// d0 uses default parameters, d1 is aimed with a short cooldown. A
// frame-level model of the laser rules predicts every output and is
// compared on each falling clock edge; directed scenarios pin the model
// with hand-computed values, then randomized frames follow.
module tb_enemy_laser_pool;

  localparam int NL = 4;
  localparam int P_CD[2]    = '{16, 5};
  localparam int P_AIMED[2] = '{0, 1};

  logic        frame_clk = 1'b0;
  logic        rst_n     = 1'b0;
  logic [5:0]  lfsr      = 6'd1;
  logic [9:0]  ex = '0, ey = '0, psx = '0, psy = '0;
  logic [9:0]  lw = 10'd2, lh = 10'd8;
  logic        alive = 1'b1;

  logic [10*NL-1:0] lx[2], ly[2];
  logic [NL-1:0]    lv[2];
  logic             ph[2];
  logic [3:0]       cnt[2];

  int tests = 0, fails = 0;
  bit chk_en = 0;

  // Model state: one entry per instance.
  int m_valid[2][NL], m_x[2][NL], m_y[2][NL];
  int m_cd[2], m_shoot[2], m_phit[2], m_cnt[2];

  always #5 frame_clk = ~frame_clk;

  enemy_laser_pool #(.NUM_LASERS(NL)) u_d0 (
    .frame_clk(frame_clk), .Reset_n(rst_n), .LFSR(lfsr), .EX(ex), .EY(ey),
    .enemy_alive(alive), .PSX(psx), .PSY(psy), .laser_width(lw),
    .laser_height(lh), .laserX(lx[0]), .laserY(ly[0]), .laser_valid(lv[0]),
    .Phit(ph[0]), .active_count(cnt[0]));

  enemy_laser_pool #(.NUM_LASERS(NL), .COOLDOWN(5), .AIMED(1), .DRIFT(1)) u_d1 (
    .frame_clk(frame_clk), .Reset_n(rst_n), .LFSR(lfsr), .EX(ex), .EY(ey),
    .enemy_alive(alive), .PSX(psx), .PSY(psy), .laser_width(lw),
    .laser_height(lh), .laserX(lx[1]), .laserY(ly[1]), .laser_valid(lv[1]),
    .Phit(ph[1]), .active_count(cnt[1]));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NL; i++) begin
        m_valid[k][i] = 0; m_x[k][i] = 0; m_y[k][i] = 0;
      end
      m_cd[k] = 0; m_shoot[k] = 0; m_phit[k] = 0; m_cnt[k] = 0;
    end
  endtask

  // One frame of the laser rules for instance k, using the current inputs.
  task automatic model_step(input int k);
    int free, hit_any, w, h, px, py, hi, x, y, n;
    bit fire;
    w = int'(lw); h = int'(lh); px = int'(psx); py = int'(psy);
    free = -1;
    for (int i = 0; i < NL; i++)
      if (free < 0 && m_valid[k][i] == 0) free = i;
    fire = (m_shoot[k] != 0) && alive && (m_cd[k] == 0) && (free >= 0);
    hit_any = 0;
    hi = (639 - w < 0) ? 0 : 639 - w;
    for (int i = 0; i < NL; i++) begin
      if (m_valid[k][i] == 0) continue;
      x = m_x[k][i]; y = m_y[k][i];
      if (y + h >= 479 - 7) begin
        m_valid[k][i] = 0; x = 0; y = 0;
      end else if (x <= px + 30 && x + w >= px && y <= py + 30 && y + h >= py) begin
        m_valid[k][i] = 0; x = 0; y = 0; hit_any = 1;
      end else begin
        y = y + 6;
        if (P_AIMED[k] != 0) begin
          if (x - px >= 1) x = x - 1;
          else if (px - x >= 1) x = x + 1;
          if (x > hi) x = hi;
        end
      end
      m_x[k][i] = x; m_y[k][i] = y;
    end
    if (fire) begin
      m_valid[k][free] = 1;
      m_x[k][free] = (int'(ex) + 2) % 1024;
      m_y[k][free] = (int'(ey) + 16) % 1024;
      m_cd[k] = P_CD[k];
    end else if (m_cd[k] > 0) begin
      m_cd[k] = m_cd[k] - 1;
    end
    m_shoot[k] = (lfsr == 6'd0) ? 1 : 0;
    m_phit[k]  = hit_any;
    n = 0;
    for (int i = 0; i < NL; i++) n += m_valid[k][i];
    m_cnt[k] = n;
  endtask

  task automatic compare_dut(input int k);
    logic [10*NL-1:0] e_x, e_y;
    logic [NL-1:0]    e_v;
    for (int i = 0; i < NL; i++) begin
      e_x[10*i +: 10] = 10'(m_x[k][i]);
      e_y[10*i +: 10] = 10'(m_y[k][i]);
      e_v[i]          = (m_valid[k][i] != 0);
    end
    check($sformatf("d%0d_laserX", k), 64'(lx[k]), 64'(e_x));
    check($sformatf("d%0d_laserY", k), 64'(ly[k]), 64'(e_y));
    check($sformatf("d%0d_valid", k), 64'(lv[k]), 64'(e_v));
    check($sformatf("d%0d_Phit", k), 64'(ph[k]), 64'(m_phit[k]));
    check($sformatf("d%0d_count", k), 64'(cnt[k]), 64'(m_cnt[k]));
  endtask

  always @(negedge frame_clk) begin
    if (chk_en) begin
      compare_dut(0);
      compare_dut(1);
    end
  end

  // Pulse reset between clock edges and confirm it acts without a clock.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_d%0d_valid", k), 64'(lv[k]), 64'd0);
      check($sformatf("rst_d%0d_laserX", k), 64'(lx[k]), 64'd0);
      check($sformatf("rst_d%0d_laserY", k), 64'(ly[k]), 64'd0);
      check($sformatf("rst_d%0d_Phit", k), 64'(ph[k]), 64'd0);
      check($sformatf("rst_d%0d_count", k), 64'(cnt[k]), 64'd0);
    end
    model_reset();
    rst_n = 1'b1;
  endtask

  // One frame: model advances, DUT sees one rising edge, return mid-low phase.
  task automatic step();
    model_step(0);
    model_step(1);
    @(posedge frame_clk);
    @(negedge frame_clk);
    #1;
  endtask

  initial begin
    model_reset();
    do_reset();
    chk_en = 1;

    // Continuous fire: spawn latency, spacing COOLDOWN+1, fill, retire, respawn.
    ex = 10'd100; ey = 10'd50; psx = 10'd500; psy = 10'd0;
    lw = 10'd2; lh = 10'd8; alive = 1'b1; lfsr = 6'd0;
    for (int e = 1; e <= 75; e++) begin
      step();
      if (e == 1) check("fill_e1_valid", 64'(lv[0]), 64'd0);
      if (e == 2) begin
        check("fill_e2_x0", 64'(lx[0][9:0]), 64'd102);
        check("fill_e2_y0", 64'(ly[0][9:0]), 64'd66);
        check("fill_e2_valid", 64'(lv[0]), 64'b0001);
        check("fill_e2_count", 64'(cnt[0]), 64'd1);
      end
      if (e == 3) begin
        check("fill_e3_y0", 64'(ly[0][9:0]), 64'd72);
        check("aim_e3_x0", 64'(lx[1][9:0]), 64'd103);
      end
      if (e == 18) check("fill_e18_valid", 64'(lv[0]), 64'b0001);
      if (e == 19) check("fill_e19_valid", 64'(lv[0]), 64'b0011);
      if (e == 60) check("fill_e60_count", 64'(cnt[0]), 64'd4);
      if (e == 70) begin
        check("retire_e70_valid", 64'(lv[0]), 64'b1110);
        check("retire_e70_count", 64'(cnt[0]), 64'd3);
      end
      if (e == 71) begin
        check("respawn_e71_valid", 64'(lv[0]), 64'b1111);
        check("respawn_e71_y0", 64'(ly[0][9:0]), 64'd66);
      end
    end

    // enemy_alive low: no new spawns, in-flight lasers keep falling; then
    // a mid-flight reset clears everything.
    do_reset();
    lfsr = 6'd0; alive = 1'b1;
    for (int e = 1; e <= 60; e++) begin
      step();
      if (e == 40) begin
        check("alive_e40_count", 64'(cnt[0]), 64'd3);
        alive = 1'b0;
      end
      if (e == 60) begin
        check("alive_e60_count", 64'(cnt[0]), 64'd3);
        check("alive_e60_y0", 64'(ly[0][9:0]), 64'd414);
      end
    end
    do_reset();
    alive = 1'b1;

    // Two lasers reach the player in the same frame: one Phit pulse.
    ex = 10'd100; ey = 10'd50; psx = 10'd100; psy = 10'd400; lfsr = 6'd0;
    for (int e = 1; e <= 60; e++) begin
      step();
      if (e == 2) ey = 10'd152;
      if (e == 18) lfsr = 6'd1;
      if (e == 57) begin
        check("hit_e57_valid", 64'(lv[0]), 64'b0011);
        check("hit_e57_y1", 64'(ly[0][19:10]), 64'd396);
        check("hit_e57_Phit", 64'(ph[0]), 64'd0);
      end
      if (e == 58) begin
        check("hit_e58_Phit", 64'(ph[0]), 64'd1);
        check("hit_e58_valid", 64'(lv[0]), 64'd0);
        check("hit_e58_xy", 64'({lx[0], ly[0]}), 64'd0);
      end
      if (e == 59) check("hit_e59_Phit", 64'(ph[0]), 64'd0);
    end

    // Aimed drift clamps: left edge at PSX=0, right edge at X_MAX-width.
    do_reset();
    ex = 10'd0; ey = 10'd50; psx = 10'd0; psy = 10'd0; lw = 10'd2; lfsr = 6'd0;
    for (int e = 1; e <= 6; e++) begin
      step();
      lfsr = 6'd1;
      if (e == 2) check("clampL_e2_x0", 64'(lx[1][9:0]), 64'd2);
      if (e == 3) check("clampL_e3_x0", 64'(lx[1][9:0]), 64'd1);
      if (e == 6) check("clampL_e6_x0", 64'(lx[1][9:0]), 64'd0);
    end
    do_reset();
    ex = 10'd620; psx = 10'd639; lw = 10'd40; lfsr = 6'd0;
    for (int e = 1; e <= 4; e++) begin
      step();
      lfsr = 6'd1;
      if (e == 3) begin
        check("clampR_e3_aimed_x0", 64'(lx[1][9:0]), 64'd599);
        check("clampR_e3_plain_x0", 64'(lx[0][9:0]), 64'd622);
      end
    end

    // Randomized frames with a slowly moving player and occasional resets.
    do_reset();
    psx = 10'($urandom_range(0, 639));
    psy = 10'($urandom_range(300, 460));
    for (int n = 0; n < 1500; n++) begin
      lfsr  = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
      alive = ($urandom_range(0, 9) != 0);
      ex    = 10'($urandom_range(0, 639));
      ey    = 10'($urandom_range(0, 460));
      lw    = 10'($urandom_range(1, 40));
      lh    = 10'($urandom_range(1, 40));
      if ($urandom_range(0, 19) == 0) begin
        psx = 10'($urandom_range(0, 639));
        psy = 10'($urandom_range(0, 479));
      end
      if ($urandom_range(0, 299) == 0) do_reset();
      step();
    end

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
